ps2_scancode_decoder: RTL and testbench

Converts the raw Set-2 byte stream from the PS/2 receiver into ASCII characters and buffers them for the CPU-side register interface. It tracks make/break/extended prefixes and the Shift and Caps Lock state, then pushes only printable or control characters into a parametrised show-ahead FIFO with a valid/ready handshake. It sits between the PS/2 bit-level receiver and the APB keyboard data register.

---
 rtl/ps2_scancode_decoder_if.sv | 19 +
 rtl/ps2_scancode_decoder.sv | 164 ++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-stream and character handshake bundle for ps2_scancode_decoder.
// Handshake: code_valid is a one-cycle strobe with no back-pressure. An ASCII entry transfers on any rising edge where ascii_valid && ascii_ready.
interface ps2_scancode_decoder_if;
  logic       code_valid;
  logic [7:0] code;
  logic       ascii_valid;
  logic       ascii_ready;
  logic [7:0] ascii;

  modport master (
    output code_valid, code, ascii_ready,
    input  ascii_valid, ascii
  );

  modport slave (
    input  code_valid, code, ascii_ready,
    output ascii_valid, ascii
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan codes in, ASCII characters out through a show-ahead FIFO with Shift and Caps Lock tracking.
// Defining PS2_SHIFT_MAP_EN enables shifted and uppercase characters. Otherwise only the unshifted US map is used.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  ps2_scancode_decoder_if.slave bus,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  shift_active,
  output logic                  caps_lock,
  output logic [1:0]            prefix_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3} state_t;

  state_t          state;
  logic            l_shift, r_shift;
  logic            letter_up, sym_up;
  logic [8:0]      lk;
  logic            push;
  logic [7:0]      push_data;
  logic            pop, full, wr_en;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  // Returns {hit, char}. Letters and control keys leave the shifted slot empty; it is filled in after the case.
  function automatic logic [8:0] lookup(input logic [7:0] c, input logic lup, input logic sup);
    logic [7:0] u, s;
    logic       hit, letter;
    u = 8'h00; s = 8'h00; hit = 1'b1;
    case (c)
      8'h1C: u = 8'h61; 8'h32: u = 8'h62; 8'h21: u = 8'h63; 8'h23: u = 8'h64;
      8'h24: u = 8'h65; 8'h2B: u = 8'h66; 8'h34: u = 8'h67; 8'h33: u = 8'h68;
      8'h43: u = 8'h69; 8'h3B: u = 8'h6A; 8'h42: u = 8'h6B; 8'h4B: u = 8'h6C;
      8'h3A: u = 8'h6D; 8'h31: u = 8'h6E; 8'h44: u = 8'h6F; 8'h4D: u = 8'h70;
      8'h15: u = 8'h71; 8'h2D: u = 8'h72; 8'h1B: u = 8'h73; 8'h2C: u = 8'h74;
      8'h3C: u = 8'h75; 8'h2A: u = 8'h76; 8'h1D: u = 8'h77; 8'h22: u = 8'h78;
      8'h35: u = 8'h79; 8'h1A: u = 8'h7A;
      8'h45: begin u = 8'h30; s = 8'h29; end
      8'h16: begin u = 8'h31; s = 8'h21; end
      8'h1E: begin u = 8'h32; s = 8'h40; end
      8'h26: begin u = 8'h33; s = 8'h23; end
      8'h25: begin u = 8'h34; s = 8'h24; end
      8'h2E: begin u = 8'h35; s = 8'h25; end
      8'h36: begin u = 8'h36; s = 8'h5E; end
      8'h3D: begin u = 8'h37; s = 8'h26; end
      8'h3E: begin u = 8'h38; s = 8'h2A; end
      8'h46: begin u = 8'h39; s = 8'h28; end
      8'h0E: begin u = 8'h60; s = 8'h7E; end
      8'h4E: begin u = 8'h2D; s = 8'h5F; end
      8'h55: begin u = 8'h3D; s = 8'h2B; end
      8'h54: begin u = 8'h5B; s = 8'h7B; end
      8'h5B: begin u = 8'h5D; s = 8'h7D; end
      8'h5D: begin u = 8'h5C; s = 8'h7C; end
      8'h4C: begin u = 8'h3B; s = 8'h3A; end
      8'h52: begin u = 8'h27; s = 8'h22; end
      8'h41: begin u = 8'h2C; s = 8'h3C; end
      8'h49: begin u = 8'h2E; s = 8'h3E; end
      8'h4A: begin u = 8'h2F; s = 8'h3F; end
      8'h29: u = 8'h20; 8'h5A: u = 8'h0D; 8'h0D: u = 8'h09;
      8'h66: u = 8'h08; 8'h76: u = 8'h1B;
      default: hit = 1'b0;
    endcase
    letter = (u >= 8'h61) && (u <= 8'h7A);
    if (letter)           s = u - 8'h20;
    else if (s == 8'h00)  s = u;
    if (letter) return {hit, (lup ? s : u)};
    else        return {hit, (sup ? s : u)};
  endfunction

`ifdef PS2_SHIFT_MAP_EN
  assign letter_up = shift_active ^ caps_lock;
  assign sym_up    = shift_active;
`else
  assign letter_up = 1'b0;
  assign sym_up    = 1'b0;
`endif

  always_comb begin
    lk        = lookup(bus.code, letter_up, sym_up);
    push      = 1'b0;
    push_data = 8'h00;
    if (bus.code_valid) begin
      case (state)
        IDLE: if (bus.code != 8'hF0 && bus.code != 8'hE0 && lk[8]) begin
          push = 1'b1; push_data = lk[7:0];
        end
        EXT: if (bus.code == 8'h5A) begin
          push = 1'b1; push_data = 8'h0D;
        end else if (bus.code == 8'h4A) begin
          push = 1'b1; push_data = 8'h2F;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      l_shift   <= 1'b0;
      r_shift   <= 1'b0;
      caps_lock <= 1'b0;
    end else if (bus.code_valid) begin
      case (state)
        IDLE: case (bus.code)
          8'hF0:   state <= BRK;
          8'hE0:   state <= EXT;
          8'h12:   l_shift <= 1'b1;
          8'h59:   r_shift <= 1'b1;
          8'h58:   caps_lock <= ~caps_lock;
          default: ;
        endcase
        BRK: if (bus.code != 8'hF0) begin
          if (bus.code == 8'h12) l_shift <= 1'b0;
          if (bus.code == 8'h59) r_shift <= 1'b0;
          state <= IDLE;
        end
        EXT: begin
          if (bus.code == 8'hF0)      state <= EXT_BRK;
          else if (bus.code != 8'hE0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign shift_active = l_shift | r_shift;
  assign prefix_state = state;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop   = bus.ascii_valid & bus.ascii_ready;
  assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(pop);
      if (ovf_clr)                  overflow <= 1'b0;
      else if (push & full & ~pop)  overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign bus.ascii_valid = (fifo_count != '0);
  assign bus.ascii       = bus.ascii_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          overflow, shift_active, caps_lock;
  logic [1:0]    prefix_state;

  ps2_scancode_decoder_if bus();

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .bus(bus), .fifo_count(fifo_count),
    .overflow(overflow), .ovf_clr(ovf_clr), .shift_active(shift_active),
    .caps_lock(caps_lock), .prefix_state(prefix_state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: lookup tables built from the key lists, prefix flags, modifier flags and an expected queue.
  logic [7:0] map_u [256];
  logic [7:0] map_s [256];
  bit         map_hit [256];
  bit         map_letter [256];
  logic [7:0] codes_list [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  bit m_brk, m_ext, m_l, m_r, m_caps, m_ovf;

  logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                          8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                          8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pc [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] pu_v [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] ps_v [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] cc [5]  = '{8'h29, 8'h5A, 8'h0D, 8'h66, 8'h76};
  logic [7:0] cv [5]  = '{8'h20, 8'h0D, 8'h09, 8'h08, 8'h1B};

  task automatic init_maps();
    string du, ds;
    du = "0123456789"; ds = ")!@#$%^&*(";
    for (int i = 0; i < 256; i++) begin
      map_u[i] = 8'h00; map_s[i] = 8'h00; map_hit[i] = 1'b0; map_letter[i] = 1'b0;
    end
    for (int i = 0; i < 26; i++) begin
      map_u[lc[i]] = 8'h61 + 8'(i); map_s[lc[i]] = 8'h41 + 8'(i);
      map_hit[lc[i]] = 1'b1; map_letter[lc[i]] = 1'b1; codes_list.push_back(lc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      map_u[dc[i]] = du[i]; map_s[dc[i]] = ds[i]; map_hit[dc[i]] = 1'b1; codes_list.push_back(dc[i]);
    end
    for (int i = 0; i < 11; i++) begin
      map_u[pc[i]] = pu_v[i]; map_s[pc[i]] = ps_v[i]; map_hit[pc[i]] = 1'b1; codes_list.push_back(pc[i]);
    end
    for (int i = 0; i < 5; i++) begin
      map_u[cc[i]] = cv[i]; map_s[cc[i]] = cv[i]; map_hit[cc[i]] = 1'b1; codes_list.push_back(cc[i]);
    end
  endtask

  function automatic logic [7:0] model_char(input logic [7:0] c);
`ifdef PS2_SHIFT_MAP_EN
    if (map_letter[c]) return ((m_l | m_r) ^ m_caps) ? map_s[c] : map_u[c];
    return (m_l | m_r) ? map_s[c] : map_u[c];
`else
    return map_u[c];
`endif
  endfunction

  task automatic model_push(input logic [7:0] ch);
    if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(ch);
  endtask

  task automatic model_code(input logic [7:0] c);
    if (m_ext && m_brk) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (m_ext) begin
      if (c == 8'hF0) m_brk = 1'b1;
      else if (c != 8'hE0) begin
        if (c == 8'h5A) model_push(8'h0D);
        else if (c == 8'h4A) model_push(8'h2F);
        m_ext = 1'b0;
      end
    end else if (m_brk) begin
      if (c != 8'hF0) begin
        if (c == 8'h12) m_l = 1'b0;
        if (c == 8'h59) m_r = 1'b0;
        m_brk = 1'b0;
      end
    end else begin
      if (c == 8'hF0) m_brk = 1'b1;
      else if (c == 8'hE0) m_ext = 1'b1;
      else if (c == 8'h12) m_l = 1'b1;
      else if (c == 8'h59) m_r = 1'b1;
      else if (c == 8'h58) m_caps = ~m_caps;
      else if (map_hit[c]) model_push(model_char(c));
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_brk = 0; m_ext = 0; m_l = 0; m_r = 0; m_caps = 0; m_ovf = 0;
  endtask

  // Drivers: inputs change on the falling edge; outputs are read there too.
  task automatic drive(input bit v, input logic [7:0] c, input bit rdy, input bit clr);
    @(negedge clock);
    bus.code_valid = v; bus.code = c; bus.ascii_ready = rdy; ovf_clr = clr;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] c);
    drive(1'b1, c, 1'b0, 1'b0);
    model_code(c);
  endtask

  task automatic drain();
    got_q.delete();
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      @(negedge clock);
      bus.code_valid = 1'b0; ovf_clr = 1'b0;
      if (!bus.ascii_valid) break;
      got_q.push_back(bus.ascii);
      bus.ascii_ready = 1'b1;
    end
    bus.ascii_ready = 1'b0;
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return codes_list[$urandom_range(0, codes_list.size() - 1)];
    if (r < 78) return 8'hF0;
    if (r < 84) return 8'hE0;
    if (r < 88) return 8'h12;
    if (r < 92) return 8'h59;
    if (r < 94) return 8'h58;
    if (r < 96) return 8'h4A;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    bus.code_valid = 1'b0; bus.code = 8'h00; bus.ascii_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (bus.ascii_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.ascii_valid); end
    n_cmp++; if (bus.ascii !== 8'h00) begin n_err++; $display("FAIL reset_ascii: got %h want 00", bus.ascii); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (shift_active !== 1'b0) begin n_err++; $display("FAIL reset_shift: got %b want 0", shift_active); end
    n_cmp++; if (caps_lock !== 1'b0) begin n_err++; $display("FAIL reset_caps: got %b want 0", caps_lock); end
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    send(8'h1C);
    idle();
    n_cmp++; if (bus.ascii_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.ascii_valid); end
    n_cmp++; if (bus.ascii !== 8'h61) begin n_err++; $display("FAIL single_ascii: got %h want 61", bus.ascii); end
    n_cmp++; if (fifo_count !== CW'(1)) begin n_err++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    idle();
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", fifo_count); end
    n_cmp++; if (bus.ascii !== 8'h00) begin n_err++; $display("FAIL single_pop_ascii: got %h want 00", bus.ascii); end
  endtask

  task automatic test_make_break();
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    idle();
    drain();
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL make_break_size: got %0d want 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_cmp++; if (got_q[i] !== 8'h61) begin n_err++; $display("FAIL make_break_data[%0d]: got %h want 61", i, got_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_shift();
    logic [7:0] want [4];
`ifdef PS2_SHIFT_MAP_EN
    want = '{8'h41, 8'h21, 8'h61, 8'h41};
`else
    want = '{8'h61, 8'h31, 8'h61, 8'h61};
`endif
    send(8'h12); send(8'h1C); send(8'h16); send(8'hF0); send(8'h12); send(8'h1C);
    send(8'h58); send(8'h1C);
    idle();
    n_cmp++; if (shift_active !== 1'b0) begin n_err++; $display("FAIL shift_state: got %b want 0", shift_active); end
    n_cmp++; if (caps_lock !== 1'b1) begin n_err++; $display("FAIL caps_state: got %b want 1", caps_lock); end
    drain();
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL shift_size: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_err++; $display("FAIL shift_data[%0d]: got %h want %h", i, got_q[i], want[i]); end
    end
    exp_q.delete();
    send(8'h59);
    idle();
    n_cmp++; if (shift_active !== 1'b1) begin n_err++; $display("FAIL rshift_make: got %b want 1", shift_active); end
    send(8'hF0); send(8'h59); send(8'h58); send(8'hF0); send(8'h58);
    idle();
    n_cmp++; if (shift_active !== 1'b0) begin n_err++; $display("FAIL rshift_break: got %b want 0", shift_active); end
    n_cmp++; if (caps_lock !== 1'b0) begin n_err++; $display("FAIL caps_retoggle: got %b want 0", caps_lock); end
  endtask

  task automatic test_extended();
    logic [7:0] seq [$];
    logic [7:0] want [3];
    want = '{8'h0D, 8'h2F, 8'h61};
    seq = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'h75, 8'hE0, 8'hE0, 8'h4A,
            8'hF0, 8'hF0, 8'h1C, 8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF, 8'hF0, 8'hAA, 8'h1C};
    foreach (seq[i]) send(seq[i]);
    idle();
    drain();
    n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL ext_size: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_err++; $display("FAIL ext_data[%0d]: got %h want %h", i, got_q[i], want[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) send(codes_list[$urandom_range(0, codes_list.size() - 1)]);
    idle();
    n_cmp++; if (fifo_count !== CW'(DEPTH)) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, DEPTH); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    drain();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_drain_size: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    m_ovf = 1'b0;
    idle();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    for (int i = 0; i < DEPTH; i++) send(codes_list[$urandom_range(0, codes_list.size() - 1)]);
    drive(1'b1, 8'h1C, 1'b0, 1'b1);
    model_code(8'h1C);
    m_ovf = 1'b0;
    idle();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr_priority: got %b want 0", overflow); end
    drain();
    n_cmp++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL ovf_refill_size: got %0d want %0d", got_q.size(), DEPTH); end
    exp_q.delete();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] c;
    logic [7:0] want_tail;
    for (int i = 0; i < DEPTH; i++) send(codes_list[$urandom_range(0, codes_list.size() - 1)]);
    c = codes_list[$urandom_range(0, codes_list.size() - 1)];
    drive(1'b1, c, 1'b1, 1'b0);
    n_cmp++; if (bus.ascii !== exp_q[0]) begin n_err++; $display("FAIL full_head: got %h want %h", bus.ascii, exp_q[0]); end
    void'(exp_q.pop_front());
    want_tail = model_char(c);
    model_code(c);
    idle();
    n_cmp++; if (fifo_count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_pp_count: got %0d want %0d", fifo_count, DEPTH); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
    drain();
    n_cmp++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL full_pp_size: got %0d want %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_pp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[got_q.size() - 1] !== want_tail) begin n_err++; $display("FAIL full_pp_tail: got %h want %h", got_q[got_q.size() - 1], want_tail); end
    end
    exp_q.delete();
    send(8'h1C); send(8'hF0);
    @(negedge clock);
    bus.code_valid = 1'b0;
    resetn = 1'b0;
    #1;
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL midreset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (bus.ascii_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", bus.ascii_valid); end
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    send(8'h1C);
    idle();
    n_cmp++; if (fifo_count !== CW'(1)) begin n_err++; $display("FAIL postreset_count: got %0d want 1", fifo_count); end
    n_cmp++; if (bus.ascii !== 8'h61) begin n_err++; $display("FAIL postreset_ascii: got %h want 61", bus.ascii); end
    drain();
    exp_q.delete();
  endtask

  task automatic test_random();
    bit v, rdy, clr;
    logic [7:0] c;
    logic [7:0] want_head;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 9) < 8);
      c   = rand_code();
      rdy = ((i % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 19) == 0);
      drive(v, c, rdy, clr);
      want_head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
      n_cmp++; if (fifo_count !== CW'(exp_q.size())) begin n_err++; $display("FAIL rand_count@%0d: got %0d want %0d", i, fifo_count, exp_q.size()); end
      n_cmp++; if (bus.ascii_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rand_valid@%0d: got %b want %b", i, bus.ascii_valid, exp_q.size() > 0); end
      n_cmp++; if (bus.ascii !== want_head) begin n_err++; $display("FAIL rand_ascii@%0d: got %h want %h", i, bus.ascii, want_head); end
      n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rand_ovf@%0d: got %b want %b", i, overflow, m_ovf); end
      n_cmp++; if (shift_active !== (m_l | m_r)) begin n_err++; $display("FAIL rand_shift@%0d: got %b want %b", i, shift_active, m_l | m_r); end
      n_cmp++; if (caps_lock !== m_caps) begin n_err++; $display("FAIL rand_caps@%0d: got %b want %b", i, caps_lock, m_caps); end
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (v) model_code(c);
      if (clr) m_ovf = 1'b0;
    end
    idle();
    drain();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_drain_size: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_drain[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  initial begin
    init_maps();
    test_reset();
    test_single();
    test_make_break();
    test_shift();
    test_extended();
    test_overflow();
    test_full_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
